ask_tx_sched: RTL and testbench

Round-robin transmit scheduler for the ASK link. It arbitrates NUM_REQ requesters that each offer a DATA_W-bit payload over a valid/ready handshake. It frames the winning payload as {stop=1, payload, start=0} and serialises it LSB-first onto the modulator input, one bit per clk. It replaces the free-running word generator as the single owner of the transmit slot.

---
 rtl/ask_tx_pkg.sv | 17 +
 rtl/ask_rr_arb.sv | 30 +++
 rtl/ask_tx_sched.sv | 149 ++++++++++++++
 tb/tb_ask_tx_sched.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ask_tx_pkg.sv
// Shared types and constants for the ASK transmit scheduler and its arbiter.
package ask_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int frame_width(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/ask_rr_arb.sv
// Combinational round-robin arbiter: the first valid at or after ptr (wrapping) wins.
module ask_rr_arb #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   index,
  output logic               any
);

  always_comb begin
    int idx;
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any && valid[idx]) begin
        any         = 1'b1;
        index       = idx[IDX_W-1:0];
        onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ask_tx_sched.sv
// Round-robin transmit scheduler: frames {stop, payload, start} and shifts LSB-first onto tx_bit.
// Optional idle fill frames are enabled with macro ASK_TX_IDLE_FILL_EN.
//
// state | meaning
// IDLE  | line high, accept window open
// SEND  | shifting frame bit bitcnt onto tx_bit
// GAP   | line high for GAP_CYCLES between frames
module ask_tx_sched
  import ask_tx_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 10,
  parameter int GAP_CYCLES = 0,
  localparam int FW    = frame_width(DATA_W),
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_bit,
  output logic [FW-1:0]             word,
  output logic                      newres,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_id
);

  localparam int BW = $clog2(FW);
  localparam logic [BW-1:0]    BIT_LAST = BW'(FW - 1);
  localparam logic [3:0]       GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  tx_state_e          state, state_nxt;
  logic [BW-1:0]      bitcnt, bit_nxt;
  logic [3:0]         gapcnt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic               accept_win, take, load;
  logic [DATA_W-1:0]  req_payload, load_payload;

  ask_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid  (req_valid),
    .ptr    (rr_ptr),
    .onehot (win_onehot),
    .index  (win_idx),
    .any    (win_any)
  );

  assign accept_win = (state == IDLE)
                   || (state == SEND && bitcnt == BIT_LAST && GAP_CYCLES == 0)
                   || (state == GAP  && gapcnt == GAP_LAST);
  assign req_ready   = (accept_win && rst_n) ? win_onehot : '0;
  assign take        = accept_win & win_any & rst_n;
  assign req_payload = req_data[win_idx*DATA_W +: DATA_W];
  assign bit_nxt     = bitcnt + 1'b1;
  assign newres      = (state == SEND) && (bitcnt == BIT_LAST);
  assign busy        = (state != IDLE);

`ifdef ASK_TX_IDLE_FILL_EN
  logic [DATA_W-1:0] fill_cnt;
  logic              fill_flag;
  logic              fill_take;

  // An empty accept window still launches a frame so the line never idles.
  assign fill_take    = accept_win & ~win_any & rst_n;
  assign load         = take | fill_take;
  assign load_payload = take ? req_payload : fill_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt  <= '0;
      fill_flag <= 1'b0;
    end else if (fill_take) begin
      fill_cnt  <= fill_cnt + 1'b1;
      fill_flag <= 1'b1;
    end else if (take) begin
      fill_flag <= 1'b0;
    end
  end
`else
  assign load         = take;
  assign load_payload = req_payload;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load) state_nxt = SEND;
      SEND: begin
        if (bitcnt == BIT_LAST) begin
          if (GAP_CYCLES > 0) state_nxt = GAP;
          else if (load)      state_nxt = SEND;
          else                state_nxt = IDLE;
        end
      end
      GAP: begin
        if (gapcnt == GAP_LAST) state_nxt = load ? SEND : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx_bit is loaded with the start bit on the transfer edge, giving 1-clk latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt   <= '0;
      gapcnt   <= '0;
      rr_ptr   <= '0;
      tx_bit   <= 1'b1;
      word     <= '0;
      grant_id <= '0;
    end else if (load) begin
      word   <= {STOP_BIT, load_payload, START_BIT};
      bitcnt <= '0;
      tx_bit <= START_BIT;
      if (take) begin
        grant_id <= win_idx;
        rr_ptr   <= (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
      end
    end else begin
      case (state)
        SEND: begin
          if (bitcnt == BIT_LAST) begin
            bitcnt <= '0;
            gapcnt <= '0;
            tx_bit <= 1'b1;
          end else begin
            bitcnt <= bit_nxt;
            tx_bit <= word[bit_nxt];
          end
        end
        GAP: begin
          gapcnt <= gapcnt + 1'b1;
          tx_bit <= 1'b1;
        end
        default: tx_bit <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_ask_tx_sched.sv
// Self-checking bench for ask_tx_sched (default build): line-level reference model plus directed checks.
module tb_ask_tx_sched;

  localparam int N  = 4;
  localparam int DW = 10;
  localparam int FW = DW + 2;

  typedef struct packed {
    logic b;
    logic stop;
    logic bsy;
  } slot_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;

  logic [N-1:0]  ready0, ready3;
  logic          tx0, tx3, nr0, nr3, busy0, busy3;
  logic [FW-1:0] word0, word3;
  logic [1:0]    gid0, gid3;

  ask_tx_sched #(.NUM_REQ(N), .DATA_W(DW), .GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready0), .tx_bit(tx0), .word(word0), .newres(nr0),
    .busy(busy0), .grant_id(gid0)
  );

  ask_tx_sched #(.NUM_REQ(N), .DATA_W(DW), .GAP_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready3), .tx_bit(tx3), .word(word3), .newres(nr3),
    .busy(busy3), .grant_id(gid3)
  );

  always #5 clk = ~clk;

  logic         sel;
  logic [N-1:0] o_ready;
  logic         o_tx, o_nr, o_busy;
  logic [1:0]   o_gid;
  assign o_ready = sel ? ready3 : ready0;
  assign o_tx    = sel ? tx3    : tx0;
  assign o_nr    = sel ? nr3    : nr0;
  assign o_busy  = sel ? busy3  : busy0;
  assign o_gid   = sel ? gid3   : gid0;

  int checks = 0;
  int errors = 0;

  slot_t        q[$];
  slot_t        cur;
  int           m_rr, m_gid, m_gap;
  int           last_acc;
  int           cyc = 0;
  logic         seen_tx, seen_nr;
  logic [N-1:0] seen_ready;
  logic         pend_v[N];
  logic [DW-1:0] pend_d[N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cur   = '{b: 1'b1, stop: 1'b0, bsy: 1'b0};
    m_rr  = 0;
    m_gid = 0;
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = pend_v[i];
      req_data[i*DW +: DW]   = pend_d[i];
    end
  endtask

  // One clock: check outputs against the model, then advance the model at the edge.
  task automatic cycle();
    int win;
    logic open;
    logic [N-1:0] exp_ready;
    #1;
    win       = pick();
    open      = (q.size() == 0);
    exp_ready = (open && win >= 0) ? N'(1 << win) : '0;
    seen_tx    = o_tx;
    seen_nr    = o_nr;
    seen_ready = o_ready;
    chk("req_ready", 32'(o_ready), 32'(exp_ready));
    chk("tx_bit",    32'(o_tx),    32'(cur.b));
    chk("newres",    32'(o_nr),    32'(cur.stop));
    chk("busy",      32'(o_busy),  32'(cur.bsy));
    chk("grant_id",  32'(o_gid),   32'(m_gid));
    @(posedge clk);
    last_acc = -1;
    if (open && win >= 0) begin
      logic [DW-1:0] d;
      d = req_data[win*DW +: DW];
      for (int i = 0; i < FW; i++) begin
        slot_t s;
        s.b    = (i == 0) ? 1'b0 : (i == FW-1) ? 1'b1 : d[i-1];
        s.stop = (i == FW-1);
        s.bsy  = 1'b1;
        q.push_back(s);
      end
      for (int g = 0; g < m_gap; g++) q.push_back('{b: 1'b1, stop: 1'b0, bsy: 1'b1});
      m_gid    = win;
      m_rr     = (win + 1) % N;
      last_acc = win;
    end
    cur = (q.size() > 0) ? q.pop_front() : '{b: 1'b1, stop: 1'b0, bsy: 1'b0};
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_pend();
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0;
      pend_d[i] = '0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    clear_pend();
    while ((q.size() > 0 || cur.bsy) && n < 40) begin
      drive();
      cycle();
      n++;
    end
    chk("drain_timeout", 32'(n < 40), 32'd1);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_phase(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < N; i++) begin
        if (last_acc == i) begin
          pend_v[i] = 1'($urandom_range(0, 1));
          pend_d[i] = DW'($urandom);
        end else if (!pend_v[i] && $urandom_range(0, 3) == 0) begin
          pend_v[i] = 1'b1;
          pend_d[i] = DW'($urandom);
        end else if (pend_v[i] && $urandom_range(0, 15) == 0) begin
          pend_v[i] = 1'b0;
        end
      end
      drive();
      cycle();
    end
  endtask

  initial begin
    int nacc, n, hi;
    int tacc[5];
    logic [FW-1:0] cap;

    sel = 1'b0;
    m_gap = 0;
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    last_acc = -1;
    clear_pend();
    model_reset();

    // Held in reset with requests present: no ready, line high.
    repeat (4) begin
      @(negedge clk);
      req_valid = N'($urandom);
      #1;
      chk("rst_ready", 32'(o_ready), 32'd0);
      chk("rst_tx",    32'(o_tx),    32'd1);
      chk("rst_busy",  32'(o_busy),  32'd0);
      chk("rst_gid",   32'(o_gid),   32'd0);
    end
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    repeat (5) begin drive(); cycle(); end

    // All four valid continuously: back-to-back grants 0,1,2,3,0 every FW clocks.
    for (int i = 0; i < N; i++) begin pend_v[i] = 1'b1; pend_d[i] = DW'($urandom); end
    nacc = 0;
    n = 0;
    while (nacc < 5 && n < 80) begin
      drive();
      cycle();
      if ((seen_ready & req_valid) != '0) begin
        chk("rr_order", 32'(seen_ready), 32'(1 << (nacc % N)));
        tacc[nacc] = cyc;
        if (nacc > 0) chk("b2b_spacing", 32'(tacc[nacc] - tacc[nacc-1]), FW);
        nacc++;
      end
      if (last_acc >= 0) pend_d[last_acc] = DW'($urandom);
      n++;
    end
    chk("b2b_timeout", 32'(nacc), 32'd5);
    drain();

    // Single requester 2 with 10'h2A5: exact serial pattern.
    pend_v[2] = 1'b1;
    pend_d[2] = 10'h2A5;
    n = 0;
    do begin drive(); cycle(); n++; end while (last_acc != 2 && n < 5);
    chk("acc2_timeout", 32'(last_acc), 32'd2);
    clear_pend();
    cap = '0;
    for (int i = 0; i < FW; i++) begin
      drive();
      cycle();
      cap[i] = seen_tx;
      if (i == FW-1) chk("newres_last", 32'(seen_nr), 32'd1);
    end
    chk("frame_2a5", 32'(cap), 32'hD4A);
    drain();

    random_phase(400);
    drain();

    // Reset mid-frame at bitcnt 5, requester 1 pending.
    pend_v[3] = 1'b1;
    pend_d[3] = DW'($urandom);
    n = 0;
    do begin drive(); cycle(); n++; end while (last_acc != 3 && n < 5);
    pend_v[3] = 1'b0;
    pend_v[1] = 1'b1;
    pend_d[1] = 10'h155;
    repeat (5) begin drive(); cycle(); end
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_tx",    32'(o_tx),    32'd1);
    chk("abort_busy",  32'(o_busy),  32'd0);
    chk("abort_ready", 32'(o_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive();
    cycle();
    chk("reserve_1", 32'(last_acc), 32'd1);
    pend_v[1] = 1'b0;
    repeat (FW + 2) begin drive(); cycle(); end
    chk("reserve_gid", 32'(o_gid), 32'd1);
    drain();

    // GAP_CYCLES=3 instance: two requesters, exactly 3 high cycles between frames.
    sel = 1'b1;
    m_gap = 3;
    reset_pulse();
    pend_v[0] = 1'b1; pend_d[0] = DW'($urandom);
    pend_v[3] = 1'b1; pend_d[3] = DW'($urandom);
    nacc = 0;
    n = 0;
    hi = -1;
    while (nacc < 4 && n < 100) begin
      drive();
      cycle();
      if (last_acc >= 0) pend_d[last_acc] = DW'($urandom);
      if (hi >= 0) begin
        if (seen_tx) hi++;
        else begin
          chk("gap_len", 32'(hi), 32'd3);
          nacc++;
          hi = -1;
        end
      end
      if (seen_nr) hi = 0;
      n++;
    end
    chk("gap_timeout", 32'(nacc), 32'd4);
    drain();
    random_phase(400);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
